serial_match_checker: RTL and testbench

SERIAL_MATCH_CHECKER -- requirements
Module: serial_match_checker

---
 rtl/serial_match_checker.sv | 167 ++++++++++++++++
 tb/tb_serial_match_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_match_checker.sv
`default_nettype none
// ============================================================================
//  Module   : serial_match_checker
//  Purpose  : Compares two serial bit streams (x, y) over a frame of FRAME_LEN
//             valid bit pairs. At frame end it reports the mismatch count, the
//             index of the first mismatching pair and an all-equal flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   sole clock, rising edge
//    rst_n          in   1   asynchronous active-low reset
//    start          in   1   begins a frame (sampled only when idle)
//    abort          in   1   cancels the running frame (wins over valid)
//    valid          in   1   qualifies x/y, one pair consumed per valid cycle
//    x, y           in   1   serial bits of stream A / stream B
//    busy           out  1   high while a frame is running
//    done           out  1   one-cycle pulse when a frame completes
//    equal          out  1   last completed frame had no mismatches
//    mismatch_cnt   out  CW  mismatching pairs in the last completed frame
//    first_mis_idx  out  CW  index of first mismatch in that frame (0 if none)
// ============================================================================
module serial_match_checker #(
   parameter int FRAME_LEN = 8,
   localparam int CW = $clog2(FRAME_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          valid,
   input  logic          x,
   input  logic          y,
   output logic          busy,
   output logic          done,
   output logic          equal,
   output logic [CW-1:0] mismatch_cnt,
   output logic [CW-1:0] first_mis_idx
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] c_last_idx = CW'(FRAME_LEN - 1);

   state_t        r_state,      w_state_nxt;
   logic [CW-1:0] r_bit_idx,    w_bit_idx_nxt;
   logic [CW-1:0] r_acc_cnt,    w_acc_cnt_nxt;
   logic [CW-1:0] r_acc_idx,    w_acc_idx_nxt;
   logic          r_first_seen, w_first_seen_nxt;
   logic          r_busy,       w_busy_nxt;
   logic          r_done,       w_done_nxt;
   logic          r_equal,      w_equal_nxt;
   logic [CW-1:0] r_mis_cnt,    w_mis_cnt_nxt;
   logic [CW-1:0] r_first_idx,  w_first_idx_nxt;

   logic          w_mis;
   logic [CW-1:0] w_cnt_inc;

   assign w_mis     = x ^ y;
   // Count including the pair being consumed this cycle; used both to update
   // the accumulator and to publish the final result on the last pair.
   assign w_cnt_inc = r_acc_cnt + CW'(w_mis);

   always_comb begin
      w_state_nxt      = r_state;
      w_bit_idx_nxt    = r_bit_idx;
      w_acc_cnt_nxt    = r_acc_cnt;
      w_acc_idx_nxt    = r_acc_idx;
      w_first_seen_nxt = r_first_seen;
      w_done_nxt       = 1'b0;
      w_equal_nxt      = r_equal;
      w_mis_cnt_nxt    = r_mis_cnt;
      w_first_idx_nxt  = r_first_idx;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt      = S_RUN;
               w_bit_idx_nxt    = '0;
               w_acc_cnt_nxt    = '0;
               w_acc_idx_nxt    = '0;
               w_first_seen_nxt = 1'b0;
            end
         end

         S_RUN: begin
            if (abort) begin
               // Drop the frame; published results stay untouched.
               w_state_nxt      = S_IDLE;
               w_bit_idx_nxt    = '0;
               w_acc_cnt_nxt    = '0;
               w_acc_idx_nxt    = '0;
               w_first_seen_nxt = 1'b0;
            end else if (valid) begin
               w_acc_cnt_nxt = w_cnt_inc;
               w_bit_idx_nxt = r_bit_idx + CW'(1);
               if (w_mis && !r_first_seen) begin
                  w_acc_idx_nxt    = r_bit_idx;
                  w_first_seen_nxt = 1'b1;
               end
               if (r_bit_idx == c_last_idx) begin
                  // The last pair is folded in directly so the result is
                  // published on DONE entry without an extra cycle.
                  w_state_nxt     = S_DONE;
                  w_done_nxt      = 1'b1;
                  w_mis_cnt_nxt   = w_cnt_inc;
                  w_equal_nxt     = (w_cnt_inc == '0);
                  if (r_first_seen) begin
                     w_first_idx_nxt = r_acc_idx;
                  end else if (w_mis) begin
                     w_first_idx_nxt = r_bit_idx;
                  end else begin
                     w_first_idx_nxt = '0;
                  end
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_bit_idx    <= '0;
         r_acc_cnt    <= '0;
         r_acc_idx    <= '0;
         r_first_seen <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_equal      <= 1'b0;
         r_mis_cnt    <= '0;
         r_first_idx  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_acc_cnt    <= w_acc_cnt_nxt;
         r_acc_idx    <= w_acc_idx_nxt;
         r_first_seen <= w_first_seen_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_equal      <= w_equal_nxt;
         r_mis_cnt    <= w_mis_cnt_nxt;
         r_first_idx  <= w_first_idx_nxt;
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign equal         = r_equal;
   assign mismatch_cnt  = r_mis_cnt;
   assign first_mis_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_serial_match_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_match_checker
//  Purpose  : Self-checking bench for serial_match_checker (FRAME_LEN = 8).
//             A queue-based frame model predicts all outputs every cycle;
//             directed frames add literal expectations on top.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_match_checker;

   localparam int FL = 8;
   localparam int CW = $clog2(FL + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          valid = 1'b0;
   logic          x = 1'b0;
   logic          y = 1'b0;
   logic          busy;
   logic          done;
   logic          equal;
   logic [CW-1:0] mismatch_cnt;
   logic [CW-1:0] first_mis_idx;

   serial_match_checker #(.FRAME_LEN(FL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .valid         (valid),
      .x             (x),
      .y             (y),
      .busy          (busy),
      .done          (done),
      .equal         (equal),
      .mismatch_cnt  (mismatch_cnt),
      .first_mis_idx (first_mis_idx)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int busy_cycles = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit   m_in_frame;
   bit   m_busy, m_done, m_equal, m_was_done;
   int   m_cnt, m_idx;
   bit   m_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_in_frame = 0; m_q.delete();
         m_busy = 0; m_done = 0; m_equal = 0; m_cnt = 0; m_idx = 0;
      end else begin
         m_was_done = m_done;
         m_done = 0;
         if (m_in_frame) begin
            if (abort) begin
               m_in_frame = 0;
               m_q.delete();
            end else if (valid) begin
               m_q.push_back(x != y);
               if (m_q.size() == FL) begin
                  int c, f;
                  c = 0; f = -1;
                  foreach (m_q[i]) if (m_q[i]) begin
                     c++;
                     if (f < 0) f = i;
                  end
                  m_cnt = c;
                  m_idx = (f < 0) ? 0 : f;
                  m_equal = (c == 0);
                  m_done = 1;
                  m_in_frame = 0;
                  m_q.delete();
               end
            end
         end else if (!m_was_done && start) begin
            m_in_frame = 1;
            m_q.delete();
         end
         m_busy = m_in_frame;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy",          busy,          m_busy);
         chk("done",          done,          m_done);
         chk("equal",         equal,         m_equal);
         chk("mismatch_cnt",  mismatch_cnt,  m_cnt);
         chk("first_mis_idx", first_mis_idx, m_idx);
      end
      if (busy) busy_cycles++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one full frame. Gap ga_len idle cycles before pair ga, gb_len
   // before pair gb. Returns one ns after the edge sampling the last pair.
   task automatic send_frame(input logic [FL-1:0] xs, input logic [FL-1:0] ys,
                             input int ga, input int ga_len,
                             input int gb, input int gb_len,
                             input bit hold_start);
      start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      for (int i = 0; i < FL; i++) begin
         if (i == ga) repeat (ga_len) begin valid = 1'b0; tick(); end
         if (i == gb) repeat (gb_len) begin valid = 1'b0; tick(); end
         valid = 1'b1; x = xs[i]; y = ys[i];
         tick();
      end
      valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [FL-1:0] pat;
      logic [FL-1:0] ones;
      logic [FL-1:0] zeros;
      logic [FL-1:0] p5;
      pat   = 8'b0100_1101;   // bit0 first: 1,0,1,1,0,0,1,0
      ones  = 8'hFF;
      zeros = 8'h00;
      p5    = 8'b0010_0000;

      cmp_en = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("reset_busy",  busy, 0);
      chk("reset_done",  done, 0);
      chk("reset_cnt",   mismatch_cnt, 0);
      #1 rst_n = 1'b1;
      tick();

      // Identical frames
      busy_cycles = 0;
      send_frame(pat, pat, -1, 0, -1, 0, 1'b0);
      @(negedge clk);
      chk("t1_done",  done, 1);
      chk("t1_equal", equal, 1);
      chk("t1_cnt",   mismatch_cnt, 0);
      chk("t1_idx",   first_mis_idx, 0);
      chk("t1_busy_cycles", busy_cycles, 8);
      tick();

      // All mismatch
      send_frame(ones, zeros, -1, 0, -1, 0, 1'b0);
      @(negedge clk);
      chk("t2_done",  done, 1);
      chk("t2_equal", equal, 0);
      chk("t2_cnt",   mismatch_cnt, 8);
      chk("t2_idx",   first_mis_idx, 0);
      tick();

      // Abort after 3 pairs
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin valid = 1'b1; x = 1'b1; y = 1'b1; tick(); end
      abort = 1'b1; tick(); abort = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("t3_busy",  busy, 0);
      chk("t3_done",  done, 0);
      chk("t3_equal", equal, 0);
      chk("t3_cnt",   mismatch_cnt, 8);
      tick(); tick();

      // Single mismatch at bit 5 with gaps of 1 and 3
      send_frame(p5, zeros, 2, 1, 6, 3, 1'b0);
      @(negedge clk);
      chk("t4_done",  done, 1);
      chk("t4_cnt",   mismatch_cnt, 1);
      chk("t4_idx",   first_mis_idx, 5);
      chk("t4_equal", equal, 0);
      tick();

      // Reset at pair 4
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin valid = 1'b1; x = 1'b1; y = 1'b0; tick(); end
      rst_n = 1'b0;
      #1;
      chk("t5_busy",  busy, 0);
      chk("t5_done",  done, 0);
      chk("t5_equal", equal, 0);
      chk("t5_cnt",   mismatch_cnt, 0);
      chk("t5_idx",   first_mis_idx, 0);
      valid = 1'b0;
      tick();
      rst_n = 1'b1;
      send_frame(pat, pat, -1, 0, -1, 0, 1'b0);
      @(negedge clk);
      chk("t5_after_done",  done, 1);
      chk("t5_after_equal", equal, 1);
      tick();

      // start held high throughout the frame, then a fresh frame
      send_frame(ones, pat, -1, 0, -1, 0, 1'b1);
      @(negedge clk);
      chk("t6_done", done, 1);
      chk("t6_cnt",  mismatch_cnt, 4);
      chk("t6_idx",  first_mis_idx, 1);
      tick();
      @(negedge clk);
      chk("t6_idle_busy", busy, 0);
      #1 start = 1'b0;
      tick();
      send_frame(zeros, p5, -1, 0, -1, 0, 1'b0);
      @(negedge clk);
      chk("t6b_cnt", mismatch_cnt, 1);
      chk("t6b_idx", first_mis_idx, 5);
      tick();

      // Randomised traffic checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         valid = ($urandom_range(0, 3) != 0);
         abort = ($urandom_range(0, 39) == 0);
         x     = $urandom_range(0, 1);
         y     = ($urandom_range(0, 2) == 0) ? ~x : x;
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         tick();
      end
      start = 1'b0; valid = 1'b0; abort = 1'b0;
      tick(); tick();
      @(negedge clk);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
